// File: rtl/weight_tile_streamer.sv
// weight_tile_streamer: streams an int8 weight matrix from beat-wide memory
// to the GEMV weight port one row tile at a time, zeroing lanes past cols.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 begin a job (sampled only when idle)
//   base_addr, rows, cols job parameters, latched on start
//   mem_req, mem_addr     one-beat read request (data returns next cycle)
//   mem_rdata             BEAT_BYTES elements, lane j at [8j+7:8j]
//   w_valid, w_ready      tile handshake toward the GEMV engine
//   w_tile_row_out        TILE_SIZE signed elements of the presented tile
//   row_idx, tile_idx     position of the presented tile
//   last_tile             presented tile is the final one of the matrix
//   busy, done            job in progress / one-cycle completion pulse
module weight_tile_streamer #(
  parameter int DATA_WIDTH  = 8,
  parameter int TILE_SIZE   = 32,
  parameter int BEAT_BYTES  = 8,
  parameter int MAX_ROWS    = 1024,
  parameter int MAX_COLUMNS = 1024,
  parameter int ADDR_WIDTH  = 24,
  localparam int MAX_DIM =
    (MAX_ROWS > MAX_COLUMNS) ? MAX_ROWS : MAX_COLUMNS,
  localparam int DIM_W = $clog2(MAX_DIM) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DIM_W-1:0]      rows,
  input  logic [DIM_W-1:0]      cols,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [BEAT_BYTES*DATA_WIDTH-1:0] mem_rdata,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic signed [DATA_WIDTH-1:0]
                                w_tile_row_out [0:TILE_SIZE-1],
  output logic [DIM_W-2:0]      row_idx,
  output logic [DIM_W-2:0]      tile_idx,
  output logic                  last_tile,
  output logic                  busy,
  output logic                  done
);

  localparam int BEATS = TILE_SIZE / BEAT_BYTES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = DIM_W - 1;
  localparam int TW    = DIM_W + 1;
  localparam int PW    = DIM_W + $clog2(TILE_SIZE) + 1;
  localparam int BDW   = BEAT_BYTES * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_STAGED,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DIM_W-1:0]      rows_q, cols_q;
  logic [TW-1:0]         tpr_q, tpr_calc;
  logic [BW-1:0]         beat_q;
  logic [IW-1:0]         f_row, f_tile;
  logic [BDW-1:0]        stage_q [BEATS];
  logic                  rd_vld;
  logic [BW-1:0]         rd_beat;

  logic                  out_vld;
  logic signed [DATA_WIDTH-1:0] out_q [TILE_SIZE];
  logic [IW-1:0]         out_row, out_tile;
  logic                  out_last;

  logic                  zero_dim, handoff, tile_wrap, f_last;
  logic [PW-1:0]         col_base;
  logic [BDW-1:0]        beat_data;
  logic signed [DATA_WIDTH-1:0] tile_view [TILE_SIZE];

  assign zero_dim = (rows == '0) || (cols == '0);
  assign tpr_calc = ({1'b0, cols} + TW'(TILE_SIZE - 1))
                    / TW'(TILE_SIZE);

  assign tile_wrap = ({2'b0, f_tile} == tpr_q - TW'(1));
  assign f_last    = ({1'b0, f_row} == rows_q - DIM_W'(1))
                     && tile_wrap;

  // The output register frees up either when empty or when its
  // current tile is accepted on this very edge.
  assign handoff = (state == S_STAGED) && (!out_vld || w_ready);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = zero_dim ? S_FINISH : S_FETCH;
      end
      S_FETCH: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (beat_q == BW'(BEATS - 1)) state_nx = S_STAGED;
      end
      S_STAGED: begin
        busy = 1'b1;
        if (handoff) begin
          if (f_last) begin
            state_nx = S_DRAIN;
          end else begin
            // first beat of the next tile overlaps the handoff
            mem_req  = 1'b1;
            state_nx = (BEATS == 1) ? S_STAGED : S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (out_vld && w_ready) state_nx = S_FINISH;
      end
      S_FINISH: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // The last beat is still on mem_rdata during the first STAGED
  // cycle, so it is merged in directly instead of waiting a cycle.
  always_comb begin
    beat_data = '0;
    col_base  = PW'(f_tile) * PW'(TILE_SIZE);
    for (int b = 0; b < BEATS; b++) begin
      beat_data = (rd_vld && rd_beat == BW'(b)) ? mem_rdata
                                                : stage_q[b];
      for (int j = 0; j < BEAT_BYTES; j++) begin
        if (col_base + PW'(b * BEAT_BYTES + j) >= PW'(cols_q))
          tile_view[b*BEAT_BYTES+j] = '0;
        else
          tile_view[b*BEAT_BYTES+j] =
            beat_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      rows_q   <= '0;
      cols_q   <= '0;
      tpr_q    <= '0;
      beat_q   <= '0;
      f_row    <= '0;
      f_tile   <= '0;
      rd_vld   <= 1'b0;
      rd_beat  <= '0;
      out_vld  <= 1'b0;
      out_row  <= '0;
      out_tile <= '0;
      out_last <= 1'b0;
      for (int i = 0; i < TILE_SIZE; i++) out_q[i] <= '0;
      for (int b = 0; b < BEATS; b++) stage_q[b] <= '0;
    end else begin
      rd_vld  <= mem_req;
      rd_beat <= beat_q;
      if (rd_vld) stage_q[rd_beat] <= mem_rdata;

      if (state == S_IDLE && start) begin
        addr_q <= base_addr;
        rows_q <= rows;
        cols_q <= cols;
        tpr_q  <= tpr_calc;
        beat_q <= '0;
        f_row  <= '0;
        f_tile <= '0;
      end

      if (mem_req) begin
        addr_q <= addr_q + ADDR_WIDTH'(BEAT_BYTES);
        beat_q <= (beat_q == BW'(BEATS - 1)) ? '0
                                             : beat_q + BW'(1);
      end

      if (handoff) begin
        out_vld  <= 1'b1;
        out_q    <= tile_view;
        out_row  <= f_row;
        out_tile <= f_tile;
        out_last <= f_last;
        if (tile_wrap) begin
          f_tile <= '0;
          f_row  <= f_row + IW'(1);
        end else begin
          f_tile <= f_tile + IW'(1);
        end
      end else if (out_vld && w_ready) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign mem_addr       = addr_q;
  assign w_valid        = out_vld;
  assign w_tile_row_out = out_q;
  assign row_idx        = out_row;
  assign tile_idx       = out_tile;
  assign last_tile      = out_last;

endmodule

// File: tb/tb_weight_tile_streamer.sv
// tb_weight_tile_streamer: randomized scoreboard bench for the weight
// tile streamer, with a tile-level reference model of the matrix walk.
module tb_weight_tile_streamer;

  logic              clk = 1'b0;
  logic              rst, start, w_ready;
  logic [23:0]       base_addr;
  logic [10:0]       rows, cols;
  logic              mem_req, w_valid, last_tile, busy, done;
  logic [23:0]       mem_addr;
  logic [63:0]       mem_rdata;
  logic signed [7:0] w_tile [0:31];
  logic [9:0]        row_idx, tile_idx;

  weight_tile_streamer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .rows(rows), .cols(cols), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .w_valid(w_valid), .w_ready(w_ready),
    .w_tile_row_out(w_tile), .row_idx(row_idx),
    .tile_idx(tile_idx), .last_tile(last_tile),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    int           row;
    int           tile;
    bit           last;
  } exp_t;

  logic [7:0] mem [0:65535];
  exp_t       tile_q [$];
  int         exp_addr_q [$];
  int         hs_log [$];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, c0 = 0;
  int req_cnt, n_xfer, first_req, last_req, first_wv;
  bit rand_ready = 0, zero_ok = 0;
  bit hold_p = 0, done_due = 0, xfer_last;
  logic [255:0] snap_d, cur;
  logic [20:0]  snap_i;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_req)
      for (int j = 0; j < 8; j++)
        mem_rdata[8*j +: 8] <= mem[(int'(mem_addr) + j) & 16'hFFFF];
    else
      mem_rdata <= {$urandom, $urandom};
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) w_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pack_tile();
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[8*i +: 8] = w_tile[i];
    return v;
  endfunction

  // Reference: row-major tile walk over a row-padded matrix layout.
  task automatic push_job(input int base, input int r, input int c);
    int tpr;
    exp_t x;
    tpr = (c + 31) / 32;
    for (int k = 0; k < r * tpr * 4; k++)
      exp_addr_q.push_back(base + 8 * k);
    for (int ri = 0; ri < r; ri++)
      for (int t = 0; t < tpr; t++) begin
        x.data = '0;
        for (int i = 0; i < 32; i++)
          if (t * 32 + i < c)
            x.data[8*i +: 8] = mem[base + (ri * tpr + t) * 32 + i];
        x.row  = ri;
        x.tile = t;
        x.last = (ri == r - 1) && (t == tpr - 1);
        tile_q.push_back(x);
      end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold_p   = 0;
      done_due = 0;
    end else begin
      if (mem_req) begin
        req_cnt++;
        if (first_req < 0) first_req = cyc;
        last_req = cyc;
        if (exp_addr_q.size() == 0) chk("mem_req_unexpected", mem_req, 0);
        else chk("mem_addr", mem_addr, exp_addr_q.pop_front());
      end
      cur = pack_tile();
      if (hold_p) begin
        chk("hold_valid", w_valid, 1);
        chk("hold_data", cur, snap_d);
        chk("hold_idx", {row_idx, tile_idx, last_tile}, snap_i);
      end
      if (w_valid && first_wv < 0) first_wv = cyc;
      xfer_last = 0;
      if (w_valid && w_ready) begin
        hs_log.push_back(cyc);
        n_xfer++;
        if (tile_q.size() == 0) begin
          chk("tile_unexpected", w_valid && w_ready, 0);
        end else begin
          e = tile_q.pop_front();
          chk("tile_data", cur, e.data);
          chk("row_idx", row_idx, e.row);
          chk("tile_idx", tile_idx, e.tile);
          chk("last_tile", last_tile, e.last);
        end
        xfer_last = last_tile;
      end
      if (done_due) begin
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
      end else if (done && !zero_ok) begin
        chk("done_spurious", done, 0);
      end
      done_due = xfer_last;
      hold_p   = w_valid && !w_ready;
      snap_d   = cur;
      snap_i   = {row_idx, tile_idx, last_tile};
    end
  end

  task automatic start_job(input int base, input int r, input int c,
                           input bit push);
    req_cnt = 0; n_xfer = 0; first_req = -1; last_req = -1;
    first_wv = -1; hs_log.delete();
    @(posedge clk); #1;
    start = 1; base_addr = 24'(base); rows = 11'(r); cols = 11'(c);
    if (push) push_job(base, r, c);
    @(posedge clk); #1;
    start = 0;
    c0 = cyc;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_timeout", seen, 1);
  endtask

  task automatic end_checks();
    chk("tiles_left", tile_q.size(), 0);
    chk("addrs_left", exp_addr_q.size(), 0);
  endtask

  task automatic wait_valid(input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(posedge clk); #1;
      if (w_valid) seen = 1;
    end
    chk("wvalid_timeout", seen, 1);
  endtask

  initial begin
    int r, c, b;
    bit got;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst = 1; start = 0; base_addr = 0; rows = 0; cols = 0; w_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_tile", pack_tile(), 0);
    chk("rst_row_idx", row_idx, 0);
    chk("rst_tile_idx", tile_idx, 0);
    chk("rst_last", last_tile, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 0;

    // free-flowing 2x64 matrix
    w_ready = 1;
    start_job('h100, 2, 64, 1);
    @(negedge clk);
    chk("busy_e0p1", busy, 1);
    chk("req_e0p1", mem_req, 1);
    wait_done(200);
    end_checks();
    chk("first_req_lat", first_req - c0, 0);
    chk("first_wvalid_lat", first_wv - c0, 5);
    chk("req_span", last_req - first_req, 15);
    chk("xfer_count", n_xfer, 4);
    if (hs_log.size() >= 4) chk("tile_period", hs_log[3] - hs_log[0], 12);
    else chk("tile_period_cnt", hs_log.size(), 4);

    // partial last tile with non-zero padding bytes in memory
    for (int i = 40; i < 64; i++) mem['h400 + i] = 8'h7F;
    rand_ready = 1;
    start_job('h400, 1, 40, 1);
    wait_done(300);
    end_checks();

    // backpressure: consumer stalls after first tile appears
    rand_ready = 0;
    #1 w_ready = 0;
    start_job('h800, 2, 64, 1);
    wait_valid(50);
    repeat (10) @(negedge clk);
    chk("stall_req_cnt", req_cnt, 8);
    chk("stall_req_off", mem_req, 0);
    @(posedge clk); #1;
    w_ready = 1;
    wait_done(200);
    end_checks();
    if (hs_log.size() >= 2) chk("release_b2b", hs_log[1] - hs_log[0], 1);
    else chk("release_cnt", hs_log.size(), 2);

    // zero dimension
    zero_ok = 1;
    start_job(0, 0, 32, 0);
    @(negedge clk);
    chk("zero_done", done, 1);
    repeat (5) @(negedge clk);
    chk("zero_no_req", req_cnt, 0);
    zero_ok = 0;

    // reset while tile 2 of 4 is presented
    w_ready = 1;
    start_job('hC00, 2, 64, 1);
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(posedge clk); #1;
      if (n_xfer >= 1) got = 1;
    end
    chk("first_xfer_timeout", got, 1);
    w_ready = 0;
    wait_valid(50);
    chk("presented_tile", tile_idx, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_wvalid", w_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req", mem_req, 0);
    tile_q.delete();
    exp_addr_q.delete();
    w_ready = 1;
    start_job('hC00, 2, 64, 1);
    wait_done(200);
    end_checks();
    chk("restart_wvalid_lat", first_wv - c0, 5);

    // second start while busy must be ignored
    rand_ready = 1;
    start_job('h1000, 2, 64, 1);
    repeat (6) @(posedge clk);
    #1 start = 1; rows = 3; cols = 96;
    @(posedge clk); #1;
    start = 0;
    wait_done(300);
    end_checks();
    chk("ignored_start_xfers", n_xfer, 4);

    // boundary and random shapes
    for (int j = 0; j < 10; j++) begin
      case (j)
        0: begin r = 1; c = 32; end
        1: begin r = 1; c = 33; end
        2: begin r = 3; c = 1;  end
        default: begin
          r = $urandom_range(1, 3);
          c = $urandom_range(1, 100);
        end
      endcase
      b = $urandom_range(0, 1500) * 32;
      start_job(b, r, c, 1);
      wait_done(1000);
      end_checks();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
